max_pool2d_2x2_stream: RTL and testbench



---
 rtl/pool_pkg.sv | 15 +
 rtl/stream_pos_counter.sv | 37 +++
 rtl/max_pool2d_2x2_stream.sv | 95 +++++++++
 tb/tb_max_pool2d_2x2_stream.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared constants, element type and signed max helper for the 2x2 max-pool stage.
package pool_pkg;
  localparam int DATA_W = 8;
  localparam int IN_W   = 12;
  localparam int IN_H   = 12;
  localparam int OUT_W  = IN_W / 2;
  localparam int OUT_H  = IN_H / 2;

  typedef logic signed [DATA_W-1:0] data_t;

  // Both operands are signed, so the compare is two's complement.
  function automatic data_t smax(input data_t a, input data_t b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/stream_pos_counter.sv
// Row/column position tracker for a row-major stream; advances only when en is high.
module stream_pos_counter #(
  parameter int W = 12,
  parameter int H = 12,
  localparam int CW = $clog2(W),
  localparam int RW = $clog2(H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          col_last,
  output logic          row_last
);
  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;

  assign col      = col_reg;
  assign row      = row_reg;
  assign col_last = (col_reg == CW'(W - 1));
  assign row_last = (row_reg == RW'(H - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (en) begin
      if (col_last) begin
        col_reg <= '0;
        row_reg <= row_last ? '0 : row_reg + RW'(1);
      end else begin
        col_reg <= col_reg + CW'(1);
      end
    end
  end
endmodule

// File: rtl/max_pool2d_2x2_stream.sv
// Streaming 2x2 stride-2 max pool: one half-width line of partial maxima plus a single in-row hold.
import pool_pkg::*;

module max_pool2d_2x2_stream #(
  parameter int IN_W = pool_pkg::IN_W,
  parameter int IN_H = pool_pkg::IN_H
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [DATA_W-1:0] layer4_out_V_data_V_dout,
  input  logic              layer4_out_V_data_V_empty_n,
  output logic              layer4_out_V_data_V_read,
  output logic [DATA_W-1:0] layer5_out_V_data_V_din,
  input  logic              layer5_out_V_data_V_full_n,
  output logic              layer5_out_V_data_V_write,
  input  logic              ap_start,
  output logic              ap_ready,
  output logic              ap_done,
  output logic              ap_idle
);
  localparam int CW   = $clog2(IN_W);
  localparam int RW   = $clog2(IN_H);
  localparam int HALF = IN_W / 2;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_last;
  logic          row_last;
  logic [CW-2:0] lb_idx;
  logic          emit;
  logic          rd;
  logic          start_unused;

  data_t x;
  data_t hold_reg;
  data_t din_reg;
  logic  write_reg;
  logic  ready_reg;
  data_t line_buf [HALF];

  assign start_unused = ap_start;
  assign x      = layer4_out_V_data_V_dout;
  assign lb_idx = col[CW-1:1];
  assign emit   = row[0] & col[0];
  // Only the window-completing element needs downstream room.
  assign rd     = layer4_out_V_data_V_empty_n & (~emit | layer5_out_V_data_V_full_n);

  stream_pos_counter #(.W(IN_W), .H(IN_H)) u_pos (
    .clk      (ap_clk),
    .rst      (ap_rst),
    .en       (rd),
    .col      (col),
    .row      (row),
    .col_last (col_last),
    .row_last (row_last)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      hold_reg  <= '0;
      din_reg   <= '0;
      write_reg <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      write_reg <= 1'b0;
      ready_reg <= 1'b0;
      if (rd) begin
        case ({row[0], col[0]})
          2'b00: hold_reg <= x;
          2'b10: hold_reg <= smax(line_buf[lb_idx], x);
          2'b11: begin
            din_reg   <= smax(hold_reg, x);
            write_reg <= 1'b1;
            ready_reg <= row_last & col_last;
          end
          default: ;
        endcase
      end
    end
  end

  // Top-row pair maxima wait here for the bottom row of the window.
  always_ff @(posedge ap_clk) begin
    if (rd && !row[0] && col[0]) begin
      line_buf[lb_idx] <= smax(hold_reg, x);
    end
  end

  assign layer4_out_V_data_V_read  = rd;
  assign layer5_out_V_data_V_din   = din_reg;
  assign layer5_out_V_data_V_write = write_reg;
  assign ap_ready = ready_reg;
  assign ap_done  = ready_reg;
  assign ap_idle  = (row == '0) && (col == '0) && !write_reg;
endmodule

// File: tb/tb_max_pool2d_2x2_stream.sv
// Self-checking bench: table of stream scenarios against a window-max reference model, plus a mid-frame reset sequence.
module tb_max_pool2d_2x2_stream;
  logic       ap_clk = 1'b0;
  logic       ap_rst;
  logic [7:0] dout;
  logic       empty_n;
  logic       rd;
  logic [7:0] din;
  logic       full_n;
  logic       wr;
  logic       ap_start;
  logic       ap_ready;
  logic       ap_done;
  logic       ap_idle;

  always #5 ap_clk = ~ap_clk;

  max_pool2d_2x2_stream dut (
    .ap_clk                      (ap_clk),
    .ap_rst                      (ap_rst),
    .layer4_out_V_data_V_dout    (dout),
    .layer4_out_V_data_V_empty_n (empty_n),
    .layer4_out_V_data_V_read    (rd),
    .layer5_out_V_data_V_din     (din),
    .layer5_out_V_data_V_full_n  (full_n),
    .layer5_out_V_data_V_write   (wr),
    .ap_start                    (ap_start),
    .ap_ready                    (ap_ready),
    .ap_done                     (ap_done),
    .ap_idle                     (ap_idle)
  );

  typedef struct {
    string name;
    int    kind;       // 0 ramp (+frame index), 1 negatives, 2 random
    int    gap_pct;
    int    stall_out;  // output count at which full_n drops for 10 cycles, -1 = never
    int    frames;
    int    exp_outputs;
    int    exp_ready;
  } case_t;

  int passed = 0;
  int total  = 0;
  int in_q[$];
  int exp_q[$];
  int out_q[$];
  int rdy_idx[$];
  int proto_err;
  int pos;
  bit pend_emit;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int sgn(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference: each output is the signed max of its 2x2 window.
  task automatic build_frame(input int kind, input int f);
    int fr[144];
    int m, s, p;
    for (int k = 0; k < 144; k++) begin
      case (kind)
        0:       fr[k] = (((k / 12) * 12 + (k % 12)) % 128 + f) & 255;
        1:       fr[k] = 8'hfb;
        default: fr[k] = int'($urandom_range(255));
      endcase
    end
    if (kind == 1) begin
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++) begin
          p = int'($urandom_range(3));
          fr[(2 * i + p / 2) * 12 + 2 * j + p % 2] = 8'h80;
        end
    end
    for (int k = 0; k < 144; k++) in_q.push_back(fr[k]);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) begin
        m = -1000;
        for (int d = 0; d < 4; d++) begin
          s = sgn(fr[(2 * i + d / 2) * 12 + 2 * j + d % 2]);
          if (s > m) m = s;
        end
        exp_q.push_back(m & 255);
      end
  endtask

  task automatic run_stream(input int gap_pct, input int stall_out, input int budget);
    int  cyc = 0;
    int  stall_left = 0;
    bit  stall_done = 0;
    int  drain = 0;
    bit  emit_m, exp_rd, timed_out;
    timed_out = 0;
    while (drain < 4) begin
      @(negedge ap_clk);
      if (wr !== pend_emit) proto_err++;
      if (ap_done !== ap_ready) proto_err++;
      if (ap_ready && !wr) proto_err++;
      if (wr) begin
        out_q.push_back(int'(din));
        if (ap_ready) rdy_idx.push_back(out_q.size() - 1);
      end
      pend_emit = 0;
      if (stall_out >= 0 && !stall_done && out_q.size() == stall_out) begin
        stall_left = 10;
        stall_done = 1;
      end
      full_n = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      empty_n = (in_q.size() > 0) && (int'($urandom_range(99)) >= gap_pct);
      dout    = (in_q.size() > 0) ? 8'(in_q[0]) : 8'h00;
      #1;
      emit_m = ((pos / 12) % 2 == 1) && ((pos % 12) % 2 == 1);
      exp_rd = empty_n && (!emit_m || full_n);
      if (rd !== exp_rd) proto_err++;
      if (rd) begin
        void'(in_q.pop_front());
        pend_emit = emit_m;
        pos = (pos + 1) % 144;
      end
      if (in_q.size() == 0 && stall_left == 0) drain++;
      cyc++;
      if (cyc > budget) begin
        timed_out = 1;
        break;
      end
    end
    empty_n = 1'b0;
    full_n  = 1'b1;
    check("run_budget", int'(timed_out), 0);
  endtask

  task automatic clear_queues();
    in_q.delete();
    exp_q.delete();
    out_q.delete();
    rdy_idx.delete();
    proto_err = 0;
  endtask

  task automatic check_outputs(input string name, input int n_out, input int n_rdy);
    check({name, "_count"}, out_q.size(), n_out);
    for (int k = 0; k < exp_q.size() && k < out_q.size(); k++)
      check($sformatf("%s_out%0d", name, k), out_q[k], exp_q[k]);
    check({name, "_ready_pulses"}, rdy_idx.size(), n_rdy);
    for (int k = 0; k < rdy_idx.size(); k++)
      check($sformatf("%s_ready_idx%0d", name, k), rdy_idx[k], 36 * k + 35);
    check({name, "_protocol"}, proto_err, 0);
    check({name, "_idle_end"}, int'(ap_idle), 1);
  endtask

  case_t cases[6];

  initial begin
    cases[0] = '{"ramp",      0, 0,  -1, 1, 36, 1};
    cases[1] = '{"negatives", 1, 0,  -1, 1, 36, 1};
    cases[2] = '{"backpress", 0, 0,   6, 1, 36, 1};
    cases[3] = '{"bursty",    0, 50, -1, 1, 36, 1};
    cases[4] = '{"two_frame", 0, 0,  -1, 2, 72, 2};
    cases[5] = '{"random",    2, 30, 20, 1, 36, 1};

    ap_rst = 1'b1; empty_n = 1'b0; full_n = 1'b1; dout = 8'h00; ap_start = 1'b0;
    pos = 0; pend_emit = 0; proto_err = 0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_write", int'(wr), 0);
    check("rst_din", int'(din), 0);
    check("rst_ready", int'(ap_ready), 0);
    check("rst_done", int'(ap_done), 0);
    check("rst_idle", int'(ap_idle), 1);
    check("rst_read", int'(rd), 0);
    ap_rst = 1'b0;

    for (int c = 0; c < 6; c++) begin
      clear_queues();
      for (int f = 0; f < cases[c].frames; f++) build_frame(cases[c].kind, f);
      run_stream(cases[c].gap_pct, cases[c].stall_out, 144 * cases[c].frames * 4 + 200);
      check_outputs(cases[c].name, cases[c].exp_outputs, cases[c].exp_ready);
      $display("case %s: %0d outputs, %0d ready pulses", cases[c].name, out_q.size(), rdy_idx.size());
    end

    // Reset after 50 inputs, then a clean frame must come out intact.
    clear_queues();
    build_frame(0, 0);
    while (in_q.size() > 50) void'(in_q.pop_back());
    run_stream(0, -1, 400);
    check("pre_reset_outputs", out_q.size(), 12);
    @(negedge ap_clk);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    check("midrst_write", int'(wr), 0);
    check("midrst_din", int'(din), 0);
    check("midrst_idle", int'(ap_idle), 1);
    ap_rst = 1'b0;
    pos = 0;
    pend_emit = 0;
    clear_queues();
    build_frame(0, 0);
    run_stream(0, -1, 800);
    check_outputs("after_reset", 36, 1);
    $display("case after_reset: %0d outputs, %0d ready pulses", out_q.size(), rdy_idx.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
